// File: rtl/imem_pkg.sv
// Shared instruction-memory definitions: capacity, word geometry and loader state encoding.
package imem_pkg;
  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int BYTES_PER_WORD   = 4;
  localparam int LANE_W           = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_t;
endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into 32-bit words; emits the completed word combinationally on the closing byte.
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter bit LITTLE_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_strobe,
  output logic        last_flag
);
  logic [LANE_W-1:0] lane;
  logic [31:0]       acc;
  logic [LANE_W-1:0] slot;

  // Accumulator is cleared after every word, so unfilled lanes read back as zero.
  assign slot = LITTLE_ENDIAN ? lane : ~lane;

  always_comb begin
    word = acc;
    word[{slot, 3'b000} +: 8] = byte_in;
  end

  assign word_strobe = strobe && (lane == LANE_W'(BYTES_PER_WORD - 1) || last);
  assign last_flag   = strobe && last;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      lane <= '0;
      acc  <= '0;
    end else if (strobe) begin
      if (word_strobe) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        acc  <= word;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes into words and writes them to the instruction memory.
module imem_loader
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS   = IMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter bit          LITTLE_ENDIAN = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  input  logic                           byte_last,
  output logic                           byte_ready,
  output logic                           mem_we,
  output logic [31:0]                    mem_addr,
  output logic [31:0]                    mem_wdata,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [$clog2(DEPTH_WORDS):0]   word_count
);
  localparam int CW = $clog2(DEPTH_WORDS) + 1;

  loader_state_t state;
  logic          ovf_pend;
  logic          xfer;
  logic          clr;
  logic [31:0]   pk_word;
  logic          pk_wstb;
  logic          pk_last;
  logic [CW-1:0] wc_inc;

  assign byte_ready = (state == LOAD);
  assign busy       = (state == LOAD) || (state == FLUSH);
  assign xfer       = byte_valid && byte_ready;
  assign clr        = start && (state == IDLE || state == DONE);
  assign wc_inc     = word_count + CW'(1);

  imem_byte_packer #(.LITTLE_ENDIAN(LITTLE_ENDIAN)) u_pack (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .byte_in     (byte_in),
    .strobe      (xfer),
    .last        (byte_last),
    .word        (pk_word),
    .word_strobe (pk_wstb),
    .last_flag   (pk_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ovf_pend   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            ovf_pend   <= 1'b0;
          end
        end
        LOAD: begin
          if (pk_wstb) begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE_ADDR + (32'(word_count) << 2);
            mem_wdata  <= pk_word;
            word_count <= wc_inc;
            // byte_last takes priority: an exact fit is not an overflow
            if (pk_last) begin
              state <= FLUSH;
            end else if (wc_inc == CW'(DEPTH_WORDS)) begin
              state    <= FLUSH;
              ovf_pend <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state    <= DONE;
          done     <= 1'b1;
          overflow <= ovf_pend;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: four configurations share one byte bus, each started separately.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  start;
  logic [7:0]  byte_in;
  logic        byte_valid, byte_last;
  logic        rdy[4], we[4], bsy[4], dn[4], ovf[4];
  logic [31:0] addr[4], wdata[4];
  logic [10:0] wc0, wc2;
  logic [2:0]  wc1;
  logic [1:0]  wc3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  imem_loader u0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(rdy[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .busy(bsy[0]), .done(dn[0]), .overflow(ovf[0]), .word_count(wc0));

  imem_loader #(.DEPTH_WORDS(4)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(rdy[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .busy(bsy[1]), .done(dn[1]), .overflow(ovf[1]), .word_count(wc1));

  imem_loader #(.LITTLE_ENDIAN(1'b0), .BASE_ADDR(32'h100)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(rdy[2]), .mem_we(we[2]), .mem_addr(addr[2]),
    .mem_wdata(wdata[2]), .busy(bsy[2]), .done(dn[2]), .overflow(ovf[2]), .word_count(wc2));

  imem_loader #(.DEPTH_WORDS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start[3]), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_last(byte_last), .byte_ready(rdy[3]), .mem_we(we[3]), .mem_addr(addr[3]),
    .mem_wdata(wdata[3]), .busy(bsy[3]), .done(dn[3]), .overflow(ovf[3]), .word_count(wc3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input int id, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.id = id; e.a = a; e.d = d;
    sbq.push_back(e);
  endtask

  // Monitor: every write strobe from any instance must match the next expected write.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: inst %0d addr %h data %h, want no write", k, addr[k], wdata[k]);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("wr_inst", 32'(k), 32'(e.id));
          chk("wr_addr", addr[k], e.a);
          chk("wr_data", wdata[k], e.d);
        end
      end
    end
  end

  task automatic send_byte(input int k, input logic [7:0] b, input logic last);
    int n;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; byte_last = last;
    n = 0;
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[k]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: inst %0d byte %h, got ready=0, want 1", k, b);
      byte_valid = 1'b0; byte_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1 byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[8];
    start = '0; byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", dn[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_ovf", ovf[0], 0);
    chk("rst_ready", rdy[0], 0);
    chk("rst_addr", addr[0], 0);
    chk("rst_wdata", wdata[0], 0);
    chk("rst_count", 32'(wc0), 0);
    reset_n = 1'b1;

    // 1: two little-endian words, no gaps
    t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    expect_wr(0, 32'h0, 32'h0000_0013);
    expect_wr(0, 32'h4, 32'h0010_0093);
    pulse_start(0);
    for (int i = 0; i < 8; i++) send_byte(0, t1[i], i == 7);
    @(negedge clk);
    chk("t1_done_n1", dn[0], 0);
    chk("t1_ready_n1", rdy[0], 0);
    chk("t1_busy_n1", bsy[0], 1);
    @(negedge clk);
    chk("t1_done_n2", dn[0], 1);
    chk("t1_count", 32'(wc0), 2);
    chk("t1_busy_n2", bsy[0], 0);

    // 2: gapped stream, partial last word zero-padded
    expect_wr(0, 32'h0, 32'h1413_1211);
    expect_wr(0, 32'h4, 32'h0000_0015);
    pulse_start(0);
    chk("t2_count_clr", 32'(wc0), 0);
    chk("t2_done_clr", dn[0], 0);
    for (int i = 0; i < 5; i++) begin
      send_byte(0, 8'(8'h11 + i), i == 4);
      if (i < 4) @(posedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t2_done", dn[0], 1);
    chk("t2_count", 32'(wc0), 2);

    // 3: capacity stop at 4 words
    expect_wr(1, 32'h0, 32'h0302_0100);
    expect_wr(1, 32'h4, 32'h0706_0504);
    expect_wr(1, 32'h8, 32'h0B0A_0908);
    expect_wr(1, 32'hC, 32'h0F0E_0D0C);
    pulse_start(1);
    for (int i = 0; i < 16; i++) send_byte(1, 8'(i), 1'b0);
    @(negedge clk);
    byte_in = 8'h10; byte_valid = 1'b1;
    chk("t3_ready_drop", rdy[1], 0);
    repeat (4) @(negedge clk);
    chk("t3_ready_hold", rdy[1], 0);
    byte_valid = 1'b0;
    chk("t3_ovf", ovf[1], 1);
    chk("t3_done", dn[1], 1);
    chk("t3_count", 32'(wc1), 4);

    // 4: reset aborts a load in progress
    expect_wr(0, 32'h0, 32'h0403_0201);
    pulse_start(0);
    for (int i = 0; i < 6; i++) send_byte(0, 8'(i + 1), 1'b0);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("t4_rst_busy", bsy[0], 0);
    chk("t4_rst_count", 32'(wc0), 0);
    chk("t4_rst_we", we[0], 0);
    repeat (3) @(negedge clk);
    expect_wr(0, 32'h0, 32'hA4A3_A2A1);
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'hA1 + i), i == 3);
    repeat (2) @(negedge clk);
    chk("t4_count", 32'(wc0), 1);
    chk("t4_done", dn[0], 1);
    chk("t4_addr", addr[0], 32'h0);

    // 5: big-endian at offset base, start during LOAD ignored
    expect_wr(2, 32'h100, 32'hDEAD_BEEF);
    pulse_start(2);
    send_byte(2, 8'hDE, 1'b0);
    send_byte(2, 8'hAD, 1'b0);
    pulse_start(2);
    chk("t5_busy", bsy[2], 1);
    send_byte(2, 8'hBE, 1'b0);
    send_byte(2, 8'hEF, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_count", 32'(wc2), 1);
    chk("t5_done", dn[2], 1);
    chk("t5_ovf", ovf[2], 0);

    // 6: exact fit with byte_last, then reload
    expect_wr(3, 32'h0, 32'h2423_2221);
    expect_wr(3, 32'h4, 32'h2827_2625);
    pulse_start(3);
    for (int i = 0; i < 8; i++) send_byte(3, 8'(8'h21 + i), i == 7);
    repeat (2) @(negedge clk);
    chk("t6_ovf", ovf[3], 0);
    chk("t6_done", dn[3], 1);
    chk("t6_count", 32'(wc3), 2);
    expect_wr(3, 32'h0, 32'h3433_3231);
    pulse_start(3);
    for (int i = 0; i < 4; i++) send_byte(3, 8'(8'h31 + i), i == 3);
    repeat (2) @(negedge clk);
    chk("t6_reload_count", 32'(wc3), 1);
    chk("t6_reload_done", dn[3], 1);
    chk("t6_reload_ovf", ovf[3], 0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
